apb_rr_master: RTL and testbench

- Two-requester APB master that shares one APB bus between two local initiators, for example a CPU port and a DMA port.
- Arbitrates round-robin and sequences the APB SETUP and ACCESS phases.
- Waits on PREADY and returns read data and completion to the granted requester.
- Sits between the initiators and the 8-bit APB slave memory.

---
 rtl/apb_rr_master_if.sv | 23 ++
 rtl/apb_rr_master.sv | 168 ++++++++++++++++
 tb/tb_apb_rr_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_master_if.sv
// APB bus bundle between apb_rr_master and a single APB slave.
interface apb_rr_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_rr_master.sv
// Two-requester round-robin APB master (IDLE -> SETUP -> ACCESS sequencing).
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,

    apb_rr_master_if.master   apb
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("apb_rr_master: TIMEOUT_CYCLES must lie in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    logic              ptr;
    logic              gnt;
    logic              pick;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    assign cnt_next = cnt + 8'd1;
`else
    assign req0_err = 1'b0;
    assign req1_err = 1'b0;
`endif

    assign apb.PSEL    = psel;
    assign apb.PENABLE = penable;
    assign apb.PWRITE  = pwrite;
    assign apb.PADDR   = paddr;
    assign apb.PWDATA  = pwdata;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~ptr;
        end else if (req1_valid) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            ptr        <= 1'b1;
            gnt        <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            cnt        <= '0;
`endif
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
`ifdef APB_TIMEOUT_EN
            req0_err  <= 1'b0;
            req1_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        gnt     <= pick;
                        ptr     <= pick;
                        pwrite  <= pick ? req1_write : req0_write;
                        paddr   <= pick ? req1_addr  : req0_addr;
                        pwdata  <= pick ? req1_wdata : req0_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
`ifdef APB_TIMEOUT_EN
                        cnt     <= '0;
`endif
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (apb.PREADY) begin
                        if (gnt) begin
                            req1_done <= 1'b1;
                            if (!pwrite) req1_rdata <= apb.PRDATA;
                        end else begin
                            req0_done <= 1'b1;
                            if (!pwrite) req0_rdata <= apb.PRDATA;
                        end
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    // PREADY has priority over a limit reached in the same cycle.
                    else if (cnt_next == TIMEOUT_LIMIT) begin
                        cnt <= cnt_next;
                        if (gnt) begin
                            req1_done  <= 1'b1;
                            req1_err   <= 1'b1;
                            req1_rdata <= '0;
                        end else begin
                            req0_done  <= 1'b1;
                            req0_err   <= 1'b1;
                            req0_rdata <= '0;
                        end
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
`endif
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: scoreboard of expected completions plus bus-timing checks.
module tb_apb_rr_master;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req0_valid, req0_write, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_write, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;

    int checks = 0;
    int failures = 0;

    apb_rr_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_rr_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req0_rdata (req0_rdata),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .req1_rdata (req1_rdata),
        .apb        (bus)
    );

    always #5 PCLK = ~PCLK;

    // Slave memory with programmable wait states
    logic [7:0] mem [256];
    int         wait_cnt = 0;
    int         ready_delay = 0;
    bit         ready_hold = 1'b0;

    assign bus.PREADY = !ready_hold && (wait_cnt >= ready_delay);
    assign bus.PRDATA = mem[bus.PADDR];

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
    end

    // Reference model and scoreboard
    typedef struct {
        bit         id;
        logic [7:0] rdata;
        bit         err;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rdata [2];

    task automatic sb_push(input bit id, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        if (wr) begin
            ref_mem[addr] = wdata;
            e.rdata = last_rdata[id];
        end else begin
            e.rdata = ref_mem[addr];
            last_rdata[id] = e.rdata;
        end
        sb.push_back(e);
    endtask

    task automatic sb_push_timeout(input bit id);
        exp_t e;
        e.id    = id;
        e.err   = 1'b1;
        e.rdata = 8'h00;
        last_rdata[id] = 8'h00;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Waits (bounded) for a done pulse; gathers bus statistics for the caller.
    task automatic await_done(input int budget, output bit found, output bit id,
                              output int ncyc, output int npsel_low, output int npen);
        found = 1'b0; id = 1'b0; ncyc = 0; npsel_low = 0; npen = 0;
        while (!found && ncyc < budget) begin
            tick();
            ncyc++;
            if (!bus.PSEL) npsel_low++;
            if (bus.PENABLE) npen++;
            if (req0_done || req1_done) begin
                found = 1'b1;
                id = req1_done;
            end
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        tick();
        tick();
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        checks++; if ({bus.PADDR, bus.PWDATA} !== 16'h0000) begin failures++; $display("FAIL reset_bus got=%0h exp=0", {bus.PADDR, bus.PWDATA}); end
        checks++; if ({req0_done, req0_err, req1_done, req1_err} !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", {req0_done, req0_err, req1_done, req1_err}); end
        checks++; if ({req0_rdata, req1_rdata} !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", {req0_rdata, req1_rdata}); end
        PRESETn = 1'b1;
        tick();
        checks++; if (bus.PSEL !== 1'b0) begin failures++; $display("FAIL idle_psel got=%b exp=0", bus.PSEL); end
    endtask

    task automatic test_single_write();
        bit found, id; int nc, nl, np; exp_t e;
        ready_hold = 0; ready_delay = 0;
        sb_push(1'b0, 1'b1, 8'h10, 8'hA5);
        req0_valid = 1; req0_write = 1; req0_addr = 8'h10; req0_wdata = 8'hA5;
        tick();
        checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b10) begin failures++; $display("FAIL setup_phase got=%b exp=10", {bus.PSEL, bus.PENABLE}); end
        checks++; if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== {1'b1, 8'h10, 8'hA5}) begin failures++; $display("FAIL setup_bus got=%0h exp=110a5", {bus.PWRITE, bus.PADDR, bus.PWDATA}); end
        req0_addr = 8'h77; req0_wdata = 8'hFF;
        tick();
        checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin failures++; $display("FAIL access_phase got=%b exp=11", {bus.PSEL, bus.PENABLE}); end
        checks++; if ({bus.PADDR, bus.PWDATA} !== {8'h10, 8'hA5}) begin failures++; $display("FAIL access_latched got=%0h exp=10a5", {bus.PADDR, bus.PWDATA}); end
        await_done(4, found, id, nc, nl, np);
        checks++; if (!found || nc != 1) begin failures++; $display("FAIL write_done_time got=%0d/%0d exp=1/1", found, nc); end
        if (found) begin
            e = sb.pop_front();
            checks++; if (id !== e.id) begin failures++; $display("FAIL write_id got=%0d exp=%0d", id, e.id); end
            checks++; if (req0_err !== e.err || req1_done !== 1'b0) begin failures++; $display("FAIL write_err got=%b%b exp=%b0", req0_err, req1_done, e.err); end
            checks++; if (req0_rdata !== e.rdata) begin failures++; $display("FAIL write_rdata got=%0h exp=%0h", req0_rdata, e.rdata); end
        end
        checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin failures++; $display("FAIL done_idle got=%b exp=00", {bus.PSEL, bus.PENABLE}); end
        req0_valid = 0;
        tick();
        checks++; if (req0_done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", req0_done); end
        checks++; if (mem[8'h10] !== 8'hA5) begin failures++; $display("FAIL slave_mem got=%0h exp=a5", mem[8'h10]); end
    endtask

    task automatic test_read_wait();
        bit found, id; int nc, nl, np; exp_t e;
        ready_hold = 0; ready_delay = 3;
        sb_push(1'b1, 1'b0, 8'h10, 8'h00);
        req1_valid = 1; req1_write = 0; req1_addr = 8'h10;
        found = 0; id = 0; nc = 0; np = 0; nl = 0;
        while (!found && nc < 20) begin
            tick();
            nc++;
            if (bus.PENABLE) np++;
            if (bus.PSEL && bus.PADDR !== 8'h10) nl++;
            if (req0_done) nl++;
            if (req1_done || req0_done) begin found = 1; id = req1_done; end
        end
        checks++; if (!found) begin failures++; $display("FAIL read_done_seen got=0 exp=1"); end
        checks++; if (np != 4) begin failures++; $display("FAIL read_penable_cycles got=%0d exp=4", np); end
        checks++; if (nl != 0) begin failures++; $display("FAIL read_stable got=%0d exp=0", nl); end
        if (found) begin
            e = sb.pop_front();
            checks++; if (id !== e.id) begin failures++; $display("FAIL read_id got=%0d exp=%0d", id, e.id); end
            checks++; if (req1_rdata !== e.rdata) begin failures++; $display("FAIL read_rdata got=%0h exp=%0h", req1_rdata, e.rdata); end
            checks++; if (req1_err !== e.err) begin failures++; $display("FAIL read_err got=%b exp=%b", req1_err, e.err); end
        end
        req1_valid = 0;
        ready_delay = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit found, id; int nc, nl, np; exp_t e; logic [7:0] rd; bit er;
        ready_hold = 0; ready_delay = 0;
        sb_push(1'b0, 1'b1, 8'h20, 8'h3C);
        sb_push(1'b1, 1'b0, 8'h20, 8'h00);
        sb_push(1'b0, 1'b1, 8'h20, 8'h5A);
        sb_push(1'b1, 1'b0, 8'h20, 8'h00);
        req0_valid = 1; req0_write = 1; req0_addr = 8'h20; req0_wdata = 8'h3C;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h20; req1_wdata = 8'h00;
        for (int k = 0; k < 4; k++) begin
            await_done(8, found, id, nc, nl, np);
            checks++; if (!found) begin failures++; $display("FAIL b2b_done_%0d got=0 exp=1", k); end
            if (found) begin
                e = sb.pop_front();
                rd = id ? req1_rdata : req0_rdata;
                er = id ? req1_err : req0_err;
                checks++; if (id !== e.id) begin failures++; $display("FAIL b2b_grant_%0d got=%0d exp=%0d", k, id, e.id); end
                checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL b2b_data_%0d got=%0h/%b exp=%0h/%b", k, rd, er, e.rdata, e.err); end
                checks++; if (nc != 3 || nl != 1) begin failures++; $display("FAIL b2b_timing_%0d got=%0d/%0d exp=3/1", k, nc, nl); end
            end
            if (k == 0) req0_wdata = 8'h5A;
            if (k == 3) begin req0_valid = 0; req1_valid = 0; end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit found, id, saw; int nc, nl, np; exp_t e;
        ready_hold = 1;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h20;
        saw = 0;
        for (int i = 0; i < 6 && !saw; i++) begin
            tick();
            if (bus.PENABLE) saw = 1;
        end
        checks++; if (!saw) begin failures++; $display("FAIL rst_reach_access got=0 exp=1"); end
        #2;
        PRESETn = 1'b0;
        #1;
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PADDR} !== 10'h000) begin failures++; $display("FAIL rst_async_bus got=%0h exp=0", {bus.PSEL, bus.PENABLE, bus.PADDR}); end
        checks++; if ({req1_done, req1_rdata} !== 9'h000) begin failures++; $display("FAIL rst_async_req1 got=%0h exp=0", {req1_done, req1_rdata}); end
        req1_valid = 0;
        last_rdata[0] = 8'h00; last_rdata[1] = 8'h00;
        tick();
        tick();
        checks++; if ({req0_done, req1_done} !== 2'b00) begin failures++; $display("FAIL rst_no_done got=%b exp=00", {req0_done, req1_done}); end
        PRESETn = 1'b1;
        ready_hold = 0;
        sb_push(1'b0, 1'b0, 8'h20, 8'h00);
        sb_push(1'b1, 1'b0, 8'h10, 8'h00);
        req0_valid = 1; req0_write = 0; req0_addr = 8'h20;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h10;
        for (int k = 0; k < 2; k++) begin
            await_done(6, found, id, nc, nl, np);
            checks++; if (!found) begin failures++; $display("FAIL post_rst_done_%0d got=0 exp=1", k); end
            if (found) begin
                e = sb.pop_front();
                checks++; if (id !== e.id) begin failures++; $display("FAIL post_rst_grant_%0d got=%0d exp=%0d", k, id, e.id); end
                checks++; if ((id ? req1_rdata : req0_rdata) !== e.rdata) begin failures++; $display("FAIL post_rst_rdata_%0d got=%0h exp=%0h", k, (id ? req1_rdata : req0_rdata), e.rdata); end
                if (id) req1_valid = 0; else req0_valid = 0;
            end
        end
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        bit found, id; int nc, nl, np; exp_t e;
        ready_hold = 1;
        sb_push_timeout(1'b0);
        req0_valid = 1; req0_write = 0; req0_addr = 8'h10;
        await_done(12, found, id, nc, nl, np);
        checks++; if (!found) begin failures++; $display("FAIL to_done got=0 exp=1"); end
        if (found) begin
            e = sb.pop_front();
            checks++; if (id !== e.id || req0_err !== e.err) begin failures++; $display("FAIL to_err got=%0d/%b exp=%0d/%b", id, req0_err, e.id, e.err); end
            checks++; if (req0_rdata !== e.rdata) begin failures++; $display("FAIL to_rdata got=%0h exp=%0h", req0_rdata, e.rdata); end
            checks++; if (np != TO) begin failures++; $display("FAIL to_access_cycles got=%0d exp=%0d", np, TO); end
            checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin failures++; $display("FAIL to_idle got=%b exp=00", {bus.PSEL, bus.PENABLE}); end
        end
        req0_valid = 0;
        tick();
        ready_hold = 0; ready_delay = TO - 1;
        sb_push(1'b0, 1'b0, 8'h10, 8'h00);
        req0_valid = 1;
        await_done(12, found, id, nc, nl, np);
        checks++; if (!found) begin failures++; $display("FAIL to_race_done got=0 exp=1"); end
        if (found) begin
            e = sb.pop_front();
            checks++; if (req0_err !== e.err || req0_rdata !== e.rdata) begin failures++; $display("FAIL to_race got=%b/%0h exp=%b/%0h", req0_err, req0_rdata, e.err, e.rdata); end
            checks++; if (np != TO) begin failures++; $display("FAIL to_race_cycles got=%0d exp=%0d", np, TO); end
        end
        req0_valid = 0;
        ready_delay = 0;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        bit found, id; int nc, nl, np; exp_t e;
        ready_hold = 1;
        sb_push(1'b0, 1'b0, 8'h10, 8'h00);
        req0_valid = 1; req0_write = 0; req0_addr = 8'h10;
        await_done(25, found, id, nc, nl, np);
        checks++; if (found) begin failures++; $display("FAIL wait_forever got=done exp=no_done"); end
        checks++; if (np != 24 || bus.PENABLE !== 1'b1) begin failures++; $display("FAIL wait_penable got=%0d/%b exp=24/1", np, bus.PENABLE); end
        checks++; if (req0_err !== 1'b0) begin failures++; $display("FAIL wait_err got=%b exp=0", req0_err); end
        ready_hold = 0;
        await_done(4, found, id, nc, nl, np);
        checks++; if (!found || nc != 1) begin failures++; $display("FAIL wait_release got=%0d/%0d exp=1/1", found, nc); end
        if (found) begin
            e = sb.pop_front();
            checks++; if (id !== e.id || req0_err !== e.err || req0_rdata !== e.rdata) begin failures++; $display("FAIL wait_result got=%0d/%b/%0h exp=%0d/%b/%0h", id, req0_err, req0_rdata, e.id, e.err, e.rdata); end
        end
        req0_valid = 0;
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        last_rdata[0] = 8'h00;
        last_rdata[1] = 8'h00;
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
